// File: rtl/prbs7_checker_if.sv
// Serial PRBS7 stream plus checker status, shared by the link driver and prbs7_checker.
// With PRBS7_CHK_BITCNT_EN defined, the locked-cycle counter bit_count is carried as well.
interface prbs7_checker_if #(
  parameter int unsigned ERR_WIDTH = 16
) ();
  logic                 en;
  logic                 data_in;
  logic                 clr_cnt;
  logic                 locked;
  logic                 err;
  logic [ERR_WIDTH-1:0] err_count;
`ifdef PRBS7_CHK_BITCNT_EN
  logic [31:0]          bit_count;

  modport master (
    output en, data_in, clr_cnt,
    input  locked, err, err_count, bit_count
  );
  modport slave (
    input  en, data_in, clr_cnt,
    output locked, err, err_count, bit_count
  );
`else
  modport master (
    output en, data_in, clr_cnt,
    input  locked, err, err_count
  );
  modport slave (
    input  en, data_in, clr_cnt,
    output locked, err, err_count
  );
`endif
endinterface

// File: rtl/prbs7_checker.sv
// Self-synchronising checker for the x^7 + x^3 + 1 PRBS stream: seeds, hunts, locks, counts errors.
// Optional: define PRBS7_CHK_BITCNT_EN to add the saturating locked-cycle counter bit_count.
module prbs7_checker #(
  parameter int unsigned LOCK_THRESH = 8,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned ERR_WIDTH   = 16
) (
  input logic            clk,
  input logic            rst,
  prbs7_checker_if.slave bus
);

  localparam int unsigned MatchW = $clog2(LOCK_THRESH + 1);
  localparam int unsigned WinW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned WerrW  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {StSeed, StHunt, StLocked} state_e;

  state_e               state_q;
  logic [7:1]           hist_q;
  logic [2:0]           fill_q;
  logic [MatchW-1:0]    match_q;
  logic [WinW-1:0]      win_cnt_q;
  logic [WerrW-1:0]     win_errs_q;
  logic                 locked_q;
  logic                 err_q;
  logic [ERR_WIDTH-1:0] err_count_q;

  logic             pred;
  logic             mismatch;
  logic             hist_zero;
  logic             win_start;
  logic [WerrW-1:0] win_errs_d;
  logic             loss;

  assign pred      = hist_q[7] ^ hist_q[3];
  assign mismatch  = bus.data_in ^ pred;
  assign hist_zero = (hist_q == 7'b0);
  assign win_start = (win_cnt_q == '0);

  // Windows tile the locked time exactly; the first cycle of each window starts a fresh tally.
  always_comb begin
    win_errs_d = win_start ? WerrW'(mismatch) : win_errs_q + WerrW'(mismatch);
    loss       = (win_errs_d >= WerrW'(LOSS_THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSeed;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_errs_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.en) begin
        hist_q <= {hist_q[6:1], bus.data_in};
        unique case (state_q)
          StSeed: begin
            if (fill_q == 3'd6) begin
              fill_q  <= '0;
              match_q <= '0;
              state_q <= StHunt;
            end else begin
              fill_q <= fill_q + 3'd1;
            end
          end
          StHunt: begin
            // An all-zero history predicts zeros forever, so it must never build toward lock.
            if (mismatch || hist_zero) begin
              match_q <= '0;
            end else if (match_q == MatchW'(LOCK_THRESH - 1)) begin
              match_q    <= '0;
              win_cnt_q  <= '0;
              win_errs_q <= '0;
              locked_q   <= 1'b1;
              state_q    <= StLocked;
            end else begin
              match_q <= match_q + MatchW'(1);
            end
          end
          StLocked: begin
            err_q      <= mismatch;
            win_errs_q <= win_errs_d;
            win_cnt_q  <= (win_cnt_q == WinW'(WINDOW - 1)) ? '0 : win_cnt_q + WinW'(1);
            if (loss || hist_zero) begin
              match_q  <= '0;
              locked_q <= 1'b0;
              state_q  <= StHunt;
            end
          end
          default: state_q <= StSeed;
        endcase
      end

      if (bus.clr_cnt) begin
        err_count_q <= '0;
      end else if (bus.en && state_q == StLocked && mismatch && !(&err_count_q)) begin
        err_count_q <= err_count_q + ERR_WIDTH'(1);
      end
    end
  end

`ifdef PRBS7_CHK_BITCNT_EN
  logic [31:0] bit_count_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      bit_count_q <= '0;
    end else if (bus.en && state_q == StLocked && !(&bit_count_q)) begin
      bit_count_q <= bit_count_q + 32'd1;
    end
  end

  assign bus.bit_count = bit_count_q;
`endif

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Receive-side checker for the 7-bit PRBS stream produced by the team's sreg7-based generator (taps x^7 + x^3 + 1; the generator's serial input is sreg[7] XOR sreg[3]).
- Takes one serial bit per enabled clock and self-synchronises to the stream.
- Declares lock, then flags and counts bit errors.
- Used to verify generator output and any serial link carrying it.

Parameters:
- LOCK_THRESH, 8: consecutive correct predictions in HUNT required to enter LOCKED.
- LOSS_THRESH, 4: errors within one window that drop LOCKED back to HUNT.
- WINDOW, 16: window length, in enabled cycles, used for loss-of-lock counting.
- ERR_WIDTH, 16: width of err_count.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  qualifies data_in; when low, all state holds.
- data_in  input  1  received serial PRBS bit.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse per mismatched bit while LOCKED.
- err_count  output  ERR_WIDTH  saturating count of errors seen while LOCKED.

Behaviour:
- Reset: only clk and rst; rst is synchronous and active-high and overrides everything, including mid-operation. Next edge gives:
  - state=SEED, hist=7'b0, fill/match/window counters 0.
  - locked=0, err=0, err_count=0.
- History register: hist[7:1], hist[1] newest. Every en cycle in every state: hist <= {hist[6:1], data_in}. The received bit is loaded even on mismatch (self-synchronising).
- Prediction: pred = hist[7] XOR hist[3], compared against data_in.
- en=0: hist, state and counters hold; err=0 that cycle.
- SEED state:
  - Counts 7 en cycles with no comparison.
  - Goes to HUNT on the edge that loads the 7th bit.
- HUNT state:
  - Match with hist != 0: match_cnt++.
  - Mismatch, or hist == 0: match_cnt=0. The zero guard stops an all-zero input from locking.
  - When match_cnt reaches LOCK_THRESH: go to LOCKED, locked=1 on that same edge, window counters cleared.
  - No err pulses and no counting in HUNT.
- LOCKED state:
  - Each en cycle: mismatch gives err=1 on the next cycle (registered, latency 1) and err_count++, saturating at 2^ERR_WIDTH-1.
  - A single flipped input bit yields exactly 3 errors, at en-cycle offsets 0, +3 and +7.
  - win_cnt counts en cycles and win_errs counts errors.
  - win_errs reaching LOSS_THRESH: state=HUNT, locked=0 on that edge, match_cnt=0.
  - win_cnt completing WINDOW cycles: both window counters restart. An error on the rollover cycle counts as 1 in the new window.
  - hist == 0 in LOCKED (stuck-at-0 input): drop to HUNT.
- clr_cnt: err_count=0 on the next edge. It has priority over a simultaneous error, so that error is not counted; err still pulses. It has no effect on state or lock.
- err_count is not cleared by loss of lock, only by rst or clr_cnt.

Optional Feature:
- Macro: PRBS7_CHK_BITCNT_EN.
- Defined:
  - Adds output bit_count [31:0].
  - Counts en cycles spent in LOCKED, saturating; cleared by rst and by clr_cnt.
  - Gives a BER denominator.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Error-free lock: rst, then drive the generator stream seeded 7'b0000001 with en=1 for 254 bits. Required: locked rises on the edge of en cycle 15 (7 SEED + 8 HUNT); err never pulses; err_count=0.
- Single bit error: while locked, invert one data_in bit. Required: err pulses exactly 3 times (offsets 0, 3, 7 en cycles); err_count=3; locked stays 1.
- Loss of lock: while locked, drive constant data_in=1. Required: 4 consecutive errors, then locked=0; afterwards no further err pulses or err_count increments.
- Zero guard: after rst, drive data_in=0 for 100 cycles. Required: locked never asserts.
- Stall and reset: repeat the first scenario with en toggling every other cycle. Required: lock after 15 en cycles and all outputs hold during en=0. Then assert rst mid-lock. Required: locked=0 and err_count=0 on the next edge.
- Count control, with ERR_WIDTH=2: force 5 errors. Required: err_count sticks at 3. Then assert clr_cnt on the same cycle as an error. Required: err_count=0 and err pulses.
